// File: rtl/srm_pkg.sv
// Shared definitions for the SRM multicycle controller, decoder and datapath:
// FSM states, datapath select codes, opcode/op constants, memory command codes.
package srm_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_DEC,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_CMP,
    S_WR_C,
    S_ADDR,
    S_LADDR,
    S_MEM_RD,
    S_GET_BD,
    S_STR_C,
    S_MEM_WR,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef struct packed {
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       write;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic       mem_req;
    logic       mem_cmd;
    logic       w;
    logic       err;
  } ctl_t;

  // State-decoded control word; opcode/op only matter in ALU (held stable in IR).
  function automatic ctl_t moore_ctl(state_t st, logic [2:0] opcode, logic [1:0] op);
    ctl_t c;
    c = '0;
    case (st)
      S_RST:    begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:    begin c.addr_sel = 1'b1; c.mem_req = 1'b1; c.mem_cmd = CMD_READ; end
      S_WR_IMM: begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM8; c.write = 1'b1; end
      S_GET_A:  begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      S_GET_B:  begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      S_ALU: begin
        c.loadc = 1'b1;
        c.asel  = (opcode == OPC_MOV && op == OP_MOV_REG) ||
                  (opcode == OPC_ALU && op == OP_MVN);
      end
      S_CMP:    c.loads = 1'b1;
      S_WR_C:   begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      S_ADDR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LADDR:  c.load_addr = 1'b1;
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.mem_cmd = CMD_READ;
        c.nsel    = NSEL_RD;
        c.vsel    = VSEL_MDATA;
      end
      S_GET_BD: begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
      S_STR_C:  begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MEM_WR: begin c.mem_req = 1'b1; c.mem_cmd = CMD_WRITE; end
      S_HALT:   c.w = 1'b1;
      S_ERR:    begin c.w = 1'b1; c.err = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/srm_ctrl_mc_if.sv
// Memory request/acknowledge port between the SRM controller and memory.
interface srm_ctrl_mc_if;
  logic mem_req;
  logic mem_cmd;
  logic mem_ack;

  modport master (output mem_req, output mem_cmd, input mem_ack);
  modport slave  (input mem_req, input mem_cmd, output mem_ack);
endinterface

// File: rtl/srm_mem_timer.sv
// Bounds a memory wait: counts unacknowledged request cycles and flags the
// cycle in which the TIMEOUT-th consecutive wait would be reached.
module srm_mem_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ack,
  output logic timeout
);

  localparam int unsigned W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!mem_req || mem_ack)
      cnt <= '0;
    else if (!timeout)
      cnt <= cnt + W'(1);
  end

  // Flag fires on the wait cycle that lands on the limit; a same-cycle ack masks it.
  if (TIMEOUT == 0) begin : g_no_timeout
    assign timeout = 1'b0;
  end else begin : g_timeout
    assign timeout = mem_req && !mem_ack && (cnt == W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/srm_ctrl_mc.sv
// Multicycle SRM controller: autonomous fetch, MOV/ALU/LDR/STR/HALT sequencing,
// bounded memory waits, sticky error and retired-instruction count.
module srm_ctrl_mc
  import srm_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_W       = 16,
  parameter bit          HALT_RESUME = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  srm_ctrl_mc_if.master    mem,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic [2:0]       nsel,
  output logic             write,
  output logic             load_ir,
  output logic             load_pc,
  output logic             reset_pc,
  output logic             load_addr,
  output logic             addr_sel,
  output logic             w,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  state_t state_n;
  ctl_t   ctl;
  logic   timeout;
  logic   retire;

  srm_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .mem_req (ctl.mem_req),
    .mem_ack (mem.mem_ack),
    .timeout (timeout)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_RST: state_n = S_IF1;
      S_IF1: begin
        if (mem.mem_ack)  state_n = S_DEC;
        else if (timeout) state_n = S_ERR;
      end
      S_DEC: begin
        state_n = S_ERR;
        if (opcode == OPC_HALT) begin
          state_n = S_HALT;
        end else begin
          case ({opcode, op})
            {OPC_MOV, OP_MOV_IMM}: state_n = S_WR_IMM;
            {OPC_MOV, OP_MOV_REG}: state_n = S_GET_B;
            {OPC_ALU, OP_ADD}:     state_n = S_GET_A;
            {OPC_ALU, OP_CMP}:     state_n = S_GET_A;
            {OPC_ALU, OP_AND}:     state_n = S_GET_A;
            {OPC_ALU, OP_MVN}:     state_n = S_GET_B;
            {OPC_LDR, 2'b00}:      state_n = S_GET_A;
            {OPC_STR, 2'b00}:      state_n = S_GET_A;
            default:               state_n = S_ERR;
          endcase
        end
      end
      S_WR_IMM: state_n = S_IF1;
      S_GET_A:  state_n = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GET_B;
      S_GET_B:  state_n = (opcode == OPC_ALU && op == OP_CMP) ? S_CMP : S_ALU;
      S_ALU:    state_n = S_WR_C;
      S_CMP:    state_n = S_IF1;
      S_WR_C:   state_n = S_IF1;
      S_ADDR:   state_n = S_LADDR;
      S_LADDR:  state_n = (opcode == OPC_LDR) ? S_MEM_RD : S_GET_BD;
      S_MEM_RD: begin
        if (mem.mem_ack)  state_n = S_IF1;
        else if (timeout) state_n = S_ERR;
      end
      S_GET_BD: state_n = S_STR_C;
      S_STR_C:  state_n = S_MEM_WR;
      S_MEM_WR: begin
        if (mem.mem_ack)  state_n = S_IF1;
        else if (timeout) state_n = S_ERR;
      end
      S_HALT:   if (s && HALT_RESUME) state_n = S_IF1;
      S_ERR:    state_n = S_ERR;
      default:  state_n = S_ERR;
    endcase
  end

  assign retire = (state_n == S_IF1  && state != S_IF1 && state != S_RST && state != S_HALT) ||
                  (state_n == S_HALT && state != S_HALT);

  // Control word is registered from the next state so outputs are glitch-free
  // and an asynchronous reset drops mem_req immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      ctl         <= moore_ctl(S_RST, '0, '0);
      instr_count <= '0;
    end else begin
      state <= state_n;
      ctl   <= moore_ctl(state_n, opcode, op);
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign load_ir   = (state == S_IF1) && mem.mem_ack;
  assign load_pc   = ctl.load_pc || load_ir;
  assign write     = ctl.write || ((state == S_MEM_RD) && mem.mem_ack);
  assign loada     = ctl.loada;
  assign loadb     = ctl.loadb;
  assign loadc     = ctl.loadc;
  assign loads     = ctl.loads;
  assign asel      = ctl.asel;
  assign bsel      = ctl.bsel;
  assign vsel      = ctl.vsel;
  assign nsel      = ctl.nsel;
  assign reset_pc  = ctl.reset_pc;
  assign load_addr = ctl.load_addr;
  assign addr_sel  = ctl.addr_sel;
  assign w         = ctl.w;
  assign err       = ctl.err;
  assign mem.mem_req = ctl.mem_req;
  assign mem.mem_cmd = ctl.mem_cmd;

endmodule

// File: tb/tb_srm_ctrl_mc.sv
// Self-checking bench for srm_ctrl_mc: directed instruction table, random
// instruction stream against a CPI-level model, and HALT/ERR/timeout/reset cases.
module tb_srm_ctrl_mc;
  import srm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s = 1'b0;
  logic [2:0] opcode = '0;
  logic [1:0] op = '0;
  logic ack = 1'b0;

  logic a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel, a_write, a_load_ir;
  logic a_load_pc, a_reset_pc, a_load_addr, a_addr_sel, a_w, a_err;
  logic [1:0] a_vsel;
  logic [2:0] a_nsel;
  logic [15:0] a_instr_count;
  logic b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel, b_write, b_load_ir;
  logic b_load_pc, b_reset_pc, b_load_addr, b_addr_sel, b_w, b_err;
  logic [1:0] b_vsel;
  logic [2:0] b_nsel;
  logic [15:0] b_instr_count;

  srm_ctrl_mc_if mif_a ();
  srm_ctrl_mc_if mif_b ();
  assign mif_a.mem_ack = ack;
  assign mif_b.mem_ack = ack;

  srm_ctrl_mc dut_a (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op), .mem(mif_a.master),
    .loada(a_loada), .loadb(a_loadb), .loadc(a_loadc), .loads(a_loads),
    .asel(a_asel), .bsel(a_bsel), .vsel(a_vsel), .nsel(a_nsel), .write(a_write),
    .load_ir(a_load_ir), .load_pc(a_load_pc), .reset_pc(a_reset_pc),
    .load_addr(a_load_addr), .addr_sel(a_addr_sel), .w(a_w), .err(a_err),
    .instr_count(a_instr_count)
  );

  srm_ctrl_mc #(.TIMEOUT(3), .CNT_W(16), .HALT_RESUME(1'b0)) dut_b (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op), .mem(mif_b.master),
    .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc), .loads(b_loads),
    .asel(b_asel), .bsel(b_bsel), .vsel(b_vsel), .nsel(b_nsel), .write(b_write),
    .load_ir(b_load_ir), .load_pc(b_load_pc), .reset_pc(b_reset_pc),
    .load_addr(b_load_addr), .addr_sel(b_addr_sel), .w(b_w), .err(b_err),
    .instr_count(b_instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    int ok, cycles, writes, loads, asels, wrcyc, loadirs;
    int wcyc, wnsel, wvsel, la, lb, lc;
  } obs_t;

  typedef struct {
    logic [2:0] opc; logic [1:0] op; int fd, dd;
    int cyc, wr, lds, asl, wrc, wcyc, wnsel, wvsel, la, lb, lc;
  } vec_t;

  // Runs one instruction starting at an IF1 negedge; ends at the next IF1 negedge.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                           input int fd, input int dd, output obs_t r);
    int waited;
    bit left;
    bit want;
    r = '{default: 0};
    waited = 0;
    left = 0;
    opcode = opc;
    op = o;
    for (int c = 1; c <= 60; c++) begin
      if (left && a_addr_sel) begin r.ok = 1; break; end
      if (!a_addr_sel) left = 1;
      s = 1'($urandom_range(0, 1));
      want = 0;
      if (mif_a.mem_req) begin
        want = ((a_addr_sel ? fd : dd) == waited);
        waited = want ? 0 : waited + 1;
      end
      ack = want;
      #1;
      r.cycles = c;
      if (a_write) begin
        r.writes++;
        if (r.wcyc == 0) begin r.wcyc = c; r.wnsel = int'(a_nsel); r.wvsel = int'(a_vsel); end
      end
      if (a_loads) r.loads++;
      if (a_asel) r.asels++;
      if (a_load_ir) r.loadirs++;
      if (mif_a.mem_req && mif_a.mem_cmd && !a_addr_sel) r.wrcyc++;
      if (a_loada && r.la == 0) r.la = c;
      if (a_loadb && r.lb == 0) r.lb = c;
      if (a_loadc && r.lc == 0) r.lc = c;
      @(negedge clk);
      ack = 0;
    end
    s = 0;
  endtask

  // Instruction-level model: cycles and pulse counts from the CPI table.
  task automatic model(input int k, input int fd, input int dd,
                       output int cyc, output int wr, output int lds,
                       output int asl, output int wrc);
    int base;
    case (k)
      0: base = 3;
      1, 3, 5: base = 5;
      2, 4, 6: base = 6;
      default: base = 8;
    endcase
    cyc = base + fd + ((k >= 6) ? dd : 0);
    wr  = (k == 3 || k == 7) ? 0 : 1;
    lds = (k == 3) ? 1 : 0;
    asl = (k == 1 || k == 5 || k == 7) ? 1 : 0;
    wrc = (k == 7) ? dd + 1 : 0;
  endtask

  task automatic do_reset();
    reset = 1; ack = 0; s = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  initial begin
    vec_t vt[11];
    obs_t r;
    logic [2:0] kopc[8];
    logic [1:0] kop[8];
    logic [20:0] rst_vec;
    logic [20:0] a_vec;
    logic [20:0] b_vec;
    int exp_ic;
    int ecyc, ewr, elds, easl, ewrc;
    bit found;

    vt[0]  = '{3'b110, 2'b10, 0, 0, 3, 1, 0, 0, 0, 3, 1, 2, 0, 0, 0};
    vt[1]  = '{3'b110, 2'b00, 0, 0, 5, 1, 0, 1, 0, 5, 2, 0, 0, 3, 4};
    vt[2]  = '{3'b101, 2'b00, 0, 0, 6, 1, 0, 0, 0, 6, 2, 0, 3, 4, 5};
    vt[3]  = '{3'b101, 2'b01, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 3, 4, 0};
    vt[4]  = '{3'b101, 2'b10, 0, 0, 6, 1, 0, 0, 0, 6, 2, 0, 3, 4, 5};
    vt[5]  = '{3'b101, 2'b11, 0, 0, 5, 1, 0, 1, 0, 5, 2, 0, 0, 3, 4};
    vt[6]  = '{3'b011, 2'b00, 0, 3, 9, 1, 0, 0, 0, 9, 2, 3, 3, 0, 4};
    vt[7]  = '{3'b100, 2'b00, 0, 0, 8, 0, 0, 1, 1, 0, 0, 0, 3, 6, 4};
    vt[8]  = '{3'b100, 2'b00, 0, 2, 10, 0, 0, 1, 3, 0, 0, 0, 3, 6, 4};
    vt[9]  = '{3'b110, 2'b10, 2, 0, 5, 1, 0, 0, 0, 5, 1, 2, 0, 0, 0};
    vt[10] = '{3'b011, 2'b00, 1, 0, 7, 1, 0, 0, 0, 7, 2, 3, 4, 0, 5};

    kopc = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101, 3'b011, 3'b100};
    kop  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};

    // Reset state
    rst_vec = {6'b0, 2'b0, 3'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0};
    @(negedge clk);
    a_vec = {a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel, a_vsel, a_nsel, a_write,
             a_load_ir, a_load_pc, a_reset_pc, a_load_addr, a_addr_sel,
             mif_a.mem_req, mif_a.mem_cmd, a_w, a_err};
    b_vec = {b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel, b_vsel, b_nsel, b_write,
             b_load_ir, b_load_pc, b_reset_pc, b_load_addr, b_addr_sel,
             mif_b.mem_req, mif_b.mem_cmd, b_w, b_err};
    chk("rst.a_outputs", a_vec, rst_vec);
    chk("rst.b_outputs", b_vec, rst_vec);
    chk("rst.a_count", a_instr_count, 0);
    reset = 0;
    @(negedge clk);
    chk("if1.addr_sel", a_addr_sel, 1);
    chk("if1.mem_req", mif_a.mem_req, 1);

    // Directed instruction table
    exp_ic = 0;
    for (int i = 0; i < 11; i++) begin
      run_instr(vt[i].opc, vt[i].op, vt[i].fd, vt[i].dd, r);
      exp_ic++;
      chk($sformatf("v%0d.done", i), r.ok, 1);
      chk($sformatf("v%0d.cycles", i), r.cycles, vt[i].cyc);
      chk($sformatf("v%0d.writes", i), r.writes, vt[i].wr);
      chk($sformatf("v%0d.loads", i), r.loads, vt[i].lds);
      chk($sformatf("v%0d.asel", i), r.asels, vt[i].asl);
      chk($sformatf("v%0d.memwr_cycles", i), r.wrcyc, vt[i].wrc);
      chk($sformatf("v%0d.load_ir", i), r.loadirs, 1);
      chk($sformatf("v%0d.write_cycle", i), r.wcyc, vt[i].wcyc);
      chk($sformatf("v%0d.write_nsel", i), r.wnsel, vt[i].wnsel);
      chk($sformatf("v%0d.write_vsel", i), r.wvsel, vt[i].wvsel);
      chk($sformatf("v%0d.loada_cycle", i), r.la, vt[i].la);
      chk($sformatf("v%0d.loadb_cycle", i), r.lb, vt[i].lb);
      chk($sformatf("v%0d.loadc_cycle", i), r.lc, vt[i].lc);
      chk($sformatf("v%0d.instr_count", i), a_instr_count, exp_ic);
    end

    // Random instruction stream against the CPI model
    for (int i = 0; i < 40; i++) begin
      int k, fd, dd;
      k  = int'($urandom_range(0, 7));
      fd = int'($urandom_range(0, 3));
      dd = int'($urandom_range(0, 3));
      model(k, fd, dd, ecyc, ewr, elds, easl, ewrc);
      run_instr(kopc[k], kop[k], fd, dd, r);
      exp_ic++;
      chk($sformatf("rnd%0d.done", i), r.ok, 1);
      chk($sformatf("rnd%0d.cycles", i), r.cycles, ecyc);
      chk($sformatf("rnd%0d.writes", i), r.writes, ewr);
      chk($sformatf("rnd%0d.loads", i), r.loads, elds);
      chk($sformatf("rnd%0d.asel", i), r.asels, easl);
      chk($sformatf("rnd%0d.memwr_cycles", i), r.wrcyc, ewrc);
      chk($sformatf("rnd%0d.instr_count", i), a_instr_count, exp_ic);
    end

    // HALT then resume
    opcode = 3'b111; op = 2'b01;
    ack = 1; #1;
    chk("halt.load_ir", a_load_ir, 1);
    @(negedge clk); ack = 0;
    chk("halt.dec_w", a_w, 0);
    @(negedge clk);
    exp_ic++;
    chk("halt.w", a_w, 1);
    chk("halt.instr_count", a_instr_count, exp_ic);
    chk("halt.mem_req", mif_a.mem_req, 0);
    @(negedge clk);
    chk("halt.hold", a_w, 1);
    s = 1;
    @(negedge clk); s = 0;
    chk("resume.if1", a_addr_sel, 1);
    chk("resume.w", a_w, 0);
    chk("resume.instr_count", a_instr_count, exp_ic);

    // Illegal opcode: ERR, s ignored, reset clears
    opcode = 3'b000; op = 2'b00;
    ack = 1; #1;
    @(negedge clk); ack = 0;
    @(negedge clk);
    chk("illegal.err", a_err, 1);
    chk("illegal.w", a_w, 1);
    s = 1;
    repeat (3) @(negedge clk);
    s = 0;
    chk("err.sticky", a_err, 1);
    chk("err.no_fetch", a_addr_sel, 0);
    chk("err.instr_count", a_instr_count, exp_ic);
    #2 reset = 1;
    #1;
    chk("err.reset_count", a_instr_count, 0);
    chk("err.reset_pc", a_reset_pc, 1);
    chk("err.reset_err", a_err, 0);
    @(negedge clk); reset = 0;
    @(negedge clk);

    // TIMEOUT=3 on dut_b: two waits pass, three waits fail
    run_instr(3'b011, 2'b00, 0, 2, r);
    chk("to2.a_done", r.ok, 1);
    chk("to2.b_err", b_err, 0);
    chk("to2.b_w", b_w, 0);
    run_instr(3'b011, 2'b00, 0, 3, r);
    chk("to3.a_done", r.ok, 1);
    chk("to3.a_err", a_err, 0);
    chk("to3.a_count", a_instr_count, 2);
    chk("to3.b_err", b_err, 1);
    chk("to3.b_w", b_w, 1);
    chk("to3.b_count", b_instr_count, 1);

    // HALT_RESUME=0 on dut_b
    do_reset();
    opcode = 3'b111; op = 2'b00;
    ack = 1; #1;
    @(negedge clk); ack = 0;
    @(negedge clk);
    chk("hr0.a_w", a_w, 1);
    chk("hr0.b_w", b_w, 1);
    s = 1;
    @(negedge clk); s = 0;
    chk("hr0.a_resumed", a_addr_sel, 1);
    chk("hr0.b_held", b_w, 1);
    chk("hr0.b_no_fetch", b_addr_sel, 0);
    repeat (2) @(negedge clk);
    chk("hr0.b_still_w", b_w, 1);
    chk("hr0.b_count", b_instr_count, 1);

    // Reset in the middle of MEM_RD drops mem_req asynchronously
    opcode = 3'b011; op = 2'b00;
    ack = 1; #1;
    @(negedge clk); ack = 0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (mif_a.mem_req && !a_addr_sel) begin found = 1; break; end
      @(negedge clk);
    end
    chk("memrd.reached", found, 1);
    #2 reset = 1;
    #1;
    chk("memrd.reset_mem_req", mif_a.mem_req, 0);
    chk("memrd.reset_pc", a_reset_pc, 1);
    @(negedge clk);
    reset = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/srm_ctrl_mc.md
# srm_ctrl_mc

Parametrised multicycle controller for the Simple RISC Machine, driving the existing instruction decoder and datapath. It fetches instructions itself over a request/acknowledge memory port, sequences MOV, ALU, LDR, STR and HALT, and bounds every memory wait with a timeout. It reports halt/error status and a retired-instruction count. It replaces the externally loaded instruction register flow (`s`/`load`) with autonomous fetch.

## Interface
- `TIMEOUT`, 16: maximum cycles a memory request may wait for `mem_ack`; 0 disables the timeout.
- `CNT_W`, 16: width of `instr_count`.
- `HALT_RESUME`, 1: 1 means `s` resumes from HALT; 0 means HALT is terminal until reset.
- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `s` in 1: resume request, sampled only in HALT.
- `opcode` in 3: from the decoder.
- `op` in 2: from the decoder.
- `mem_ack` in 1: memory done, valid in the same cycle as `mem_req`; read data is valid on `mdata` when it is high.
- `loada`, `loadb`, `loadc`, `loads` out 1: datapath register enables.
- `asel`, `bsel` out 1: `asel=1` forces A to 0; `bsel=1` selects `sximm5`.
- `vsel` out 2: writeback select.
- `nsel` out 3: one-hot register select.
- `write` out 1: register file write.
- `load_ir`, `load_pc`, `reset_pc`, `load_addr`, `addr_sel` out 1: fetch and address control. `addr_sel=1` drives the PC onto the memory address; `addr_sel=0` drives the data address register.
- `mem_req` out 1: memory request.
- `mem_cmd` out 1: 0 = read, 1 = write.
- `w` out 1: waiting (HALT or ERR).
- `err` out 1: sticky error.
- `instr_count` out `CNT_W`: retired instructions.

## Operation
- All outputs are decoded from the state (Moore), with three exceptions that are qualified by `mem_ack`:
  - `load_ir` and `load_pc` in IF1.
  - `write` in MEM_RD.
- Encodings:
  - `vsel`: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
  - `nsel`: 001 = Rn, 010 = Rd, 100 = Rm.
- States and asserted outputs:
  - RST: `reset_pc` and `load_pc` → IF1.
  - IF1: `addr_sel`, `mem_req`, `mem_cmd=0`. Holds while `mem_ack` is 0. On ack, asserts `load_ir` and `load_pc` (PC+1) → DEC.
  - DEC: no outputs. Dispatches as follows:
    - {110,10} → WR_IMM.
    - {110,00} → GET_B.
    - {101,00}, {101,01}, {101,10} → GET_A.
    - {101,11} → GET_B.
    - {011,00} → GET_A.
    - {100,00} → GET_A.
    - {111,xx} → HALT.
    - Anything else → ERR.
  - WR_IMM: `nsel=Rn`, `vsel=10`, `write` → IF1.
  - GET_A: `nsel=Rn`, `loada`. Next state is ADDR for LDR/STR, otherwise GET_B.
  - GET_B: `nsel=Rm`, `loadb`. Next state is CMP for CMP, otherwise ALU.
  - ALU: `loadc`; `asel=1` for MOV-reg and MVN → WR_C.
  - CMP: `loads` → IF1.
  - WR_C: `nsel=Rd`, `vsel=00`, `write` → IF1.
  - ADDR: `bsel`, `loadc` → LADDR.
  - LADDR: `load_addr`. Next state is MEM_RD for LDR, GET_BD for STR.
  - MEM_RD: `mem_req`, `mem_cmd=0`, `nsel=Rd`, `vsel=11`. On `mem_ack`, asserts `write` → IF1.
  - GET_BD: `nsel=Rd`, `loadb` → STR_C.
  - STR_C: `asel`, `loadc` → MEM_WR. The shift is forced to 0 by the decoder.
  - MEM_WR: `mem_req`, `mem_cmd=1`. Holds until `mem_ack` → IF1.
  - HALT: `w`. Goes to IF1 when `s=1` and `HALT_RESUME=1`.
  - ERR: `w`, `err`. Only `reset` exits.
- Retire: `instr_count` increments by 1 on every transition into IF1 from any state except RST and HALT, and on entry to HALT. It wraps modulo 2^`CNT_W`.
- Timeout:
  - The wait counter resets whenever `mem_req` is 0 or `mem_ack` is 1.
  - It increments on each cycle with `mem_req=1` and `mem_ack=0`.
  - When it reaches `TIMEOUT` (nonzero), the next state is ERR.
  - An ack arriving in the same cycle as the limit wins; no error is raised.

## Timing
- Reset (asynchronous) forces state RST, wait counter 0, `instr_count` 0. While in RST, all outputs are 0 except `reset_pc` and `load_pc`, which are 1.
- Reset mid-operation aborts at once. Any `mem_req` drops in the same cycle.
- Cycles per instruction with zero-wait memory:
  - MOV imm: 3.
  - MOV reg, MVN: 5.
  - CMP: 5.
  - ADD, AND: 6.
  - LDR: 6.
  - STR: 8.
  - Each memory wait cycle adds 1.
- `w` rises in the first cycle in HALT or ERR.
- `s` in HALT leaves HALT after 1 cycle.
- `s` outside HALT is ignored.

## Structure
- `srm_pkg` holds:
  - the state enum;
  - `vsel` and `nsel` codes;
  - opcode/op constants;
  - the `mem_cmd` codes.
  The decoder and datapath import it.
- Sub-module `srm_mem_timer`: the wait counter and the `timeout` flag, parametrised by `TIMEOUT`. Its width is $clog2(`TIMEOUT`+1).
- The FSM and the retire counter live in `srm_ctrl_mc`.

## Test plan
- MOV R0,#7 (`16'b110_10_000_00000111`), always-ack memory → `write`, `nsel=001`, `vsel=10` in cycle 3 after IF1. `instr_count`=1 on return to IF1.
- ADD R2,R1,R0 then HALT → `loada`, `loadb`, `loadc`, `write` in cycles 3/4/5/6. Then `w=1`, `instr_count`=2. `s` pulse → IF1.
- LDR with `mem_ack` delayed 3 cycles → MEM_RD holds 4 cycles and `write` pulses only in the ack cycle. With `TIMEOUT`=3, the same delay → ERR, `err=1`.
- STR → MEM_WR asserts `mem_cmd=1`, `addr_sel=0`. Total 8 cycles with zero-wait memory.
- Illegal `opcode`=000 → ERR. `s` is ignored. `reset` → RST with `instr_count`=0.
- `HALT_RESUME`=0 → `s` in HALT is ignored. `reset` asserted mid-MEM_RD → `mem_req` drops asynchronously.
